// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use, branch-operand and mult/div stall controller
// Drives the ID/EX bubble and front-end hold from the ID and EX instruction words.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 16,
  parameter int CNT_W    = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IF_ID_Instr,
  input  logic [31:0] ID_EX_Instr,
  output logic        Stall_en,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        MD_busy,
  output logic [2:0]  Stall_cause
);

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_LOAD    = 3'd1,
    CAUSE_BR_ALU  = 3'd2,
    CAUSE_BR_LOAD = 3'd3,
    CAUSE_MD      = 3'd4
  } cause_e;

  logic [5:0] ex_op, ex_fn, id_op, id_fn;
  logic [4:0] ex_rt, ex_rd, id_rs, id_rt;

  assign ex_op = ID_EX_Instr[31:26];
  assign ex_rt = ID_EX_Instr[20:16];
  assign ex_rd = ID_EX_Instr[15:11];
  assign ex_fn = ID_EX_Instr[5:0];
  assign id_op = IF_ID_Instr[31:26];
  assign id_rs = IF_ID_Instr[25:21];
  assign id_rt = IF_ID_Instr[20:16];
  assign id_fn = IF_ID_Instr[5:0];

  logic unused_ok;
  assign unused_ok = ^{ID_EX_Instr[25:21], ID_EX_Instr[10:6], IF_ID_Instr[15:6]};

  logic ex_rtype, ex_load, ex_alu, ex_md;
  logic [4:0] ex_alu_dest;
  logic id_rtype, id_use_rs, id_use_rt, id_branch, id_md, id_hilo;

  always_comb begin
    ex_rtype = (ex_op == 6'h00);
    ex_load  = (ex_op == 6'h20) || (ex_op == 6'h21) || (ex_op == 6'h23) ||
               (ex_op == 6'h24) || (ex_op == 6'h25);
    ex_md    = ex_rtype && (ex_fn[5:2] == 4'b0110);
    ex_alu   = (ex_rtype && (ex_fn != 6'h08) && !ex_md) || (ex_op[5:3] == 3'b001);
    ex_alu_dest = ex_rtype ? ex_rd : ex_rt;

    id_rtype  = (id_op == 6'h00);
    id_use_rs = !((id_op == 6'h0F) || (id_op == 6'h02) || (id_op == 6'h03) ||
                  (id_rtype && ((id_fn == 6'h00) || (id_fn == 6'h02) || (id_fn == 6'h03))));
    id_use_rt = id_rtype || (id_op == 6'h04) || (id_op == 6'h05) ||
                (id_op == 6'h28) || (id_op == 6'h29) || (id_op == 6'h2B);
    id_branch = (id_op == 6'h04) || (id_op == 6'h05) || (id_rtype && (id_fn == 6'h08));
    id_md     = id_rtype && (id_fn[5:2] == 4'b0110);
    id_hilo   = id_rtype && ((id_fn == 6'h10) || (id_fn == 6'h12));
  end

  function automatic logic src_match(input logic [4:0] dest, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
    return (dest != 5'd0) && ((use_rs && (rs == dest)) || (use_rt && (rt == dest)));
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic br_wait_q, br_wait_d;
  logic load_use, br_alu, md_haz;

  assign MD_busy  = (cnt_q != '0) || ex_md;
  assign load_use = ex_load && src_match(ex_rt, id_rs, id_rt, id_use_rs, id_use_rt);
  assign br_alu   = id_branch && ex_alu &&
                    src_match(ex_alu_dest, id_rs, id_rt, id_use_rs, id_use_rt);
  assign md_haz   = (id_md || id_hilo) && MD_busy;

  // A branch behind a load needs the loaded value one stage later than ALU results.
  assign br_wait_d = id_branch && load_use;

  always_comb begin
    Stall_cause = CAUSE_NONE;
    if (br_wait_q)     Stall_cause = CAUSE_BR_LOAD;
    else if (md_haz)   Stall_cause = CAUSE_MD;
    else if (load_use) Stall_cause = CAUSE_LOAD;
    else if (br_alu)   Stall_cause = CAUSE_BR_ALU;
  end

  assign Stall_en = br_wait_q || md_haz || load_use || br_alu;
  assign PC_en    = !Stall_en;
  assign IF_ID_en = !Stall_en;

  always_comb begin
    cnt_d = cnt_q;
    if (ex_md)
      cnt_d = ex_fn[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      br_wait_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      br_wait_q <= br_wait_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed vector bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IF_ID_Instr = '0;
  logic [31:0] ID_EX_Instr = '0;
  logic        Stall_en, PC_en, IF_ID_en, MD_busy;
  logic [2:0]  Stall_cause;

  int total = 0;
  int bad   = 0;

  hazard_stall_ctrl #(.MULT_LAT(4), .DIV_LAT(16), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .IF_ID_Instr(IF_ID_Instr), .ID_EX_Instr(ID_EX_Instr),
    .Stall_en(Stall_en), .PC_en(PC_en), .IF_ID_en(IF_ID_en),
    .MD_busy(MD_busy), .Stall_cause(Stall_cause)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] LW8      = 32'h8C28_0000;
  localparam logic [31:0] ADD_9_8  = 32'h0102_4820;
  localparam logic [31:0] BEQ8     = 32'h1100_0003;
  localparam logic [31:0] BNE8     = 32'h1500_0003;
  localparam logic [31:0] ADD8     = 32'h0022_4020;
  localparam logic [31:0] DIV12    = 32'h0022_001A;
  localparam logic [31:0] MULT12   = 32'h0022_0018;
  localparam logic [31:0] MFLO3    = 32'h0000_1812;
  localparam logic [31:0] MFHI3    = 32'h0000_1810;
  localparam logic [31:0] MULT_8_2 = 32'h0102_0018;

  typedef struct {
    logic [31:0] ex;
    logic [31:0] id;
    logic        st;
    logic [2:0]  cause;
    logic        md;
  } vec_t;

  vec_t tbl[16];

  // Inputs are applied just after a rising edge; outputs sampled on the falling edge.
  task automatic cyc(input logic [31:0] ex, input logic [31:0] id, input string nm,
                     input logic st, input logic [2:0] cause, input logic md);
    logic [6:0] act, exp;
    ID_EX_Instr = ex;
    IF_ID_Instr = id;
    @(negedge CLK);
    act = {Stall_en, PC_en, IF_ID_en, MD_busy, Stall_cause};
    exp = {st, ~st, ~st, md, cause};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got stall=%b pc=%b ifid=%b md=%b cause=%0d, want stall=%b pc=%b ifid=%b md=%b cause=%0d",
               nm, act[6], act[5], act[4], act[3], act[2:0], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tbl[0]  = '{LW8,          ADD_9_8,      1'b1, 3'd1, 1'b0};
    tbl[1]  = '{NOP,          NOP,          1'b0, 3'd0, 1'b0};
    tbl[2]  = '{32'h8C20_0000, 32'h0002_4820, 1'b0, 3'd0, 1'b0};
    tbl[3]  = '{LW8,          32'h3C08_0000, 1'b0, 3'd0, 1'b0};
    tbl[4]  = '{LW8,          32'hAC28_0000, 1'b1, 3'd1, 1'b0};
    tbl[5]  = '{LW8,          32'h0900_0000, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{LW8,          32'h0008_4880, 1'b1, 3'd1, 1'b0};
    tbl[7]  = '{LW8,          32'h0100_4882, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{ADD8,         BNE8,         1'b1, 3'd2, 1'b0};
    tbl[9]  = '{32'h2028_0005, BEQ8,        1'b1, 3'd2, 1'b0};
    tbl[10] = '{32'h2028_0005, ADD_9_8,     1'b0, 3'd0, 1'b0};
    tbl[11] = '{ADD8,         32'h0100_0008, 1'b1, 3'd2, 1'b0};
    tbl[12] = '{32'h8028_0000, ADD_9_8,     1'b1, 3'd1, 1'b0};
    tbl[13] = '{32'h9428_0000, 32'h1120_0003, 1'b0, 3'd0, 1'b0};
    tbl[14] = '{32'hAC28_0000, ADD_9_8,     1'b0, 3'd0, 1'b0};
    tbl[15] = '{32'h0022_0020, 32'h1400_0003, 1'b0, 3'd0, 1'b0};

    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc(NOP, NOP, "reset_state", 1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 16; i++)
      cyc(tbl[i].ex, tbl[i].id, $sformatf("vec%0d", i), tbl[i].st, tbl[i].cause, tbl[i].md);

    // Branch behind a load: two stall cycles, then release.
    cyc(LW8, BEQ8, "brload_c1", 1'b1, 3'd1, 1'b0);
    cyc(NOP, BEQ8, "brload_c2", 1'b1, 3'd3, 1'b0);
    cyc(NOP, BEQ8, "brload_c3", 1'b0, 3'd0, 1'b0);
    cyc(ADD8, BNE8, "bralu_c1", 1'b1, 3'd2, 1'b0);
    cyc(NOP, BNE8, "bralu_c2", 1'b0, 3'd0, 1'b0);

    // Divide: 1 cycle in EX plus DIV_LAT busy cycles.
    cyc(DIV12, MFLO3, "div_ex", 1'b1, 3'd4, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 5)
        cyc(LW8, MULT_8_2, "div_prio_md_over_load", 1'b1, 3'd4, 1'b1);
      else
        cyc(NOP, MFLO3, $sformatf("div_busy%0d", k), 1'b1, 3'd4, 1'b1);
    end
    cyc(NOP, MFLO3, "div_release", 1'b0, 3'd0, 1'b0);
    cyc(NOP, MFLO3, "div_idle", 1'b0, 3'd0, 1'b0);

    // Multiply: 5 stall cycles.
    cyc(MULT12, MFHI3, "mult_ex", 1'b1, 3'd4, 1'b1);
    for (int k = 1; k <= 4; k++)
      cyc(NOP, MFHI3, $sformatf("mult_busy%0d", k), 1'b1, 3'd4, 1'b1);
    cyc(NOP, MFHI3, "mult_release", 1'b0, 3'd0, 1'b0);

    // Forced mult while divide counter is still running: reload to MULT_LAT.
    cyc(DIV12, NOP, "reload_div", 1'b0, 3'd0, 1'b1);
    cyc(NOP, NOP, "reload_gap", 1'b0, 3'd0, 1'b1);
    cyc(MULT12, MFLO3, "reload_mult", 1'b1, 3'd4, 1'b1);
    for (int k = 1; k <= 4; k++)
      cyc(NOP, MFLO3, $sformatf("reload_busy%0d", k), 1'b1, 3'd4, 1'b1);
    cyc(NOP, MFLO3, "reload_release", 1'b0, 3'd0, 1'b0);

    // Reset during the second branch-load stall cycle.
    cyc(LW8, BEQ8, "rst2_c1", 1'b1, 3'd1, 1'b0);
    RST = 1'b1;
    cyc(NOP, BEQ8, "rst2_c2", 1'b1, 3'd3, 1'b0);
    RST = 1'b0;
    cyc(NOP, BEQ8, "rst2_after", 1'b0, 3'd0, 1'b0);

    // Reset during the first cycle must drop the pending second stall.
    RST = 1'b1;
    cyc(LW8, BEQ8, "rst1_c1", 1'b1, 3'd1, 1'b0);
    RST = 1'b0;
    cyc(NOP, BEQ8, "rst1_after", 1'b0, 3'd0, 1'b0);

    // Reset with a divide pending clears the busy counter.
    cyc(DIV12, NOP, "rstdiv_ex", 1'b0, 3'd0, 1'b1);
    cyc(NOP, MFLO3, "rstdiv_busy", 1'b1, 3'd4, 1'b1);
    RST = 1'b1;
    cyc(NOP, MFLO3, "rstdiv_in_reset", 1'b1, 3'd4, 1'b1);
    RST = 1'b0;
    cyc(NOP, MFLO3, "rstdiv_after", 1'b0, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
